// File: rtl/shift_reg_univ_if.sv
// Command/data bundle for shift_reg_univ_seq.
//   slave  : the shift register (accepts commands, drives q/status)
//   master : the command issuer (drives commands, serial inputs, par_in)
//   cmd_valid/cmd_ready/cmd_op/cmd_cnt : command handshake and payload
//   par_in, sin_l, sin_r              : parallel and serial data inputs
//   q, sout_msb, sout_lsb             : register contents and serial taps
//   busy, done, err                   : status
interface shift_reg_univ_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic [WIDTH-1:0] par_in;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] q;
  logic             sout_msb;
  logic             sout_lsb;
  logic             busy;
  logic             done;
  logic             err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_cnt, par_in, sin_l, sin_r,
    output cmd_ready, q, sout_msb, sout_lsb, busy, done, err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_cnt, par_in, sin_l, sin_r,
    input  cmd_ready, q, sout_msb, sout_lsb, busy, done, err
  );
endinterface

// File: rtl/shift_reg_univ_seq.sv
// Universal shift register with command sequencer: parallel load, logical
// shift left/right and rotate left/right by a programmable step count, one
// single-bit step per clock.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : shift_reg_univ_if slave modport (commands, data, status)
module shift_reg_univ_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input logic             clk,
  input logic             rst_n,
  shift_reg_univ_if.slave bus
);

  localparam logic [2:0] OP_HOLD = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_SHR  = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;
  localparam logic [2:0] OP_ROR  = 3'd5;

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [2:0]       op_q, op_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // One single-bit step of a shift/rotate op; other opcodes leave v unchanged.
  function automatic logic [WIDTH-1:0] do_step(input logic [2:0] op,
                                               input logic [WIDTH-1:0] v,
                                               input logic sl, input logic sr);
    logic [WIDTH-1:0] r;
    r = v;
    case (op)
      OP_SHL:  r = {v[WIDTH-2:0], sl};
      OP_SHR:  r = {sr, v[WIDTH-1:1]};
      OP_ROL:  r = {v[WIDTH-2:0], v[WIDTH-1]};
      OP_ROR:  r = {v[0], v[WIDTH-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      rem_q   <= '0;
      op_q    <= OP_HOLD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: the first step runs on the acceptance edge, so RUN only
  // covers the remaining cnt-1 steps.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rem_d   = rem_q;
    op_d    = op_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            OP_HOLD: done_d = 1'b1;
            OP_LOAD: begin
              q_d    = bus.par_in;
              done_d = 1'b1;
            end
            OP_SHL, OP_SHR, OP_ROL, OP_ROR: begin
              if (bus.cmd_cnt == '0) begin
                done_d = 1'b1;
              end else begin
                q_d = do_step(bus.cmd_op, q_q, bus.sin_l, bus.sin_r);
                if (bus.cmd_cnt == CNT_W'(1)) begin
                  done_d = 1'b1;
                end else begin
                  rem_d   = bus.cmd_cnt - CNT_W'(1);
                  op_d    = bus.cmd_op;
                  busy_d  = 1'b1;
                  state_d = RUN;
                end
              end
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      RUN: begin
        q_d = do_step(op_q, q_q, bus.sin_l, bus.sin_r);
        if (rem_q == CNT_W'(1)) begin
          rem_d   = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          rem_d = rem_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.q         = q_q;
  assign bus.sout_msb  = q_q[WIDTH-1];
  assign bus.sout_lsb  = q_q[0];
  assign bus.busy      = busy_q;
  assign bus.cmd_ready = ~busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_shift_reg_univ_seq.sv
// Directed self-checking bench for shift_reg_univ_seq (WIDTH=8, CNT_W=4).
module tb_shift_reg_univ_seq;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  shift_reg_univ_if #(.WIDTH(8), .CNT_W(4)) bus ();

  shift_reg_univ_seq #(.WIDTH(8), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle past it before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a command for exactly one edge (accepted when idle).
  task automatic issue(input logic [2:0] op, input logic [3:0] cnt, input logic [7:0] par);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_cnt   = cnt;
    bus.par_in    = par;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // After the acceptance edge: count edges and busy cycles until done.
  task automatic wait_done(output int edges, output int busy_cyc, output bit timeout);
    edges = 1; busy_cyc = 0; timeout = 1'b0;
    while (bus.done !== 1'b1) begin
      if (edges > 40) begin
        timeout = 1'b1;
        return;
      end
      if (bus.busy === 1'b1) busy_cyc++;
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd1; bus.par_in = 8'hFF;
    tick(); tick();
    total++; if (bus.q !== 8'h00) begin bad++; $display("FAIL reset_q got=%h exp=00", bus.q); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.cmd_ready); end
    bus.cmd_valid = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load();
    issue(3'd1, 4'd0, 8'hA5);
    total++; if (bus.q !== 8'hA5) begin bad++; $display("FAIL load_q got=%h exp=a5", bus.q); end
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL load_done got=%b exp=1", bus.done); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL load_busy got=%b exp=0", bus.busy); end
    total++; if ({bus.sout_msb, bus.sout_lsb} !== 2'b11) begin bad++; $display("FAIL load_sout got=%b exp=11", {bus.sout_msb, bus.sout_lsb}); end
    tick();
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL load_done_pulse got=%b exp=0", bus.done); end
    issue(3'd0, 4'd5, 8'h00);
    total++; if (bus.q !== 8'hA5 || bus.done !== 1'b1) begin bad++; $display("FAIL hold got q=%h done=%b exp q=a5 done=1", bus.q, bus.done); end
    tick();
    issue(3'd2, 4'd0, 8'h00);
    total++; if (bus.q !== 8'hA5 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL shl_cnt0 got q=%h done=%b busy=%b exp q=a5 done=1 busy=0", bus.q, bus.done, bus.busy); end
    tick();
  endtask

  task automatic test_rotate();
    int e, b; bit to;
    issue(3'd1, 4'd0, 8'h81); tick();
    issue(3'd4, 4'd3, 8'h00);
    total++; if (bus.q !== 8'h03 || bus.busy !== 1'b1) begin bad++; $display("FAIL rol_step1 got q=%h busy=%b exp q=03 busy=1", bus.q, bus.busy); end
    wait_done(e, b, to);
    total++; if (to) begin bad++; $display("FAIL rol_timeout got=timeout exp=done"); end
    total++; if (bus.q !== 8'h0C) begin bad++; $display("FAIL rol_q got=%h exp=0c", bus.q); end
    total++; if (e !== 3 || b !== 2) begin bad++; $display("FAIL rol_timing got edges=%0d busy=%0d exp edges=3 busy=2", e, b); end
    total++; if ({bus.sout_msb, bus.sout_lsb} !== 2'b00) begin bad++; $display("FAIL rol_sout got=%b exp=00", {bus.sout_msb, bus.sout_lsb}); end
    tick();
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rol_done_once got=%b exp=0", bus.done); end
    issue(3'd1, 4'd0, 8'h3C); tick();
    issue(3'd5, 4'd8, 8'h00);
    wait_done(e, b, to);
    total++; if (to || bus.q !== 8'h3C || e !== 8 || b !== 7) begin bad++; $display("FAIL ror8 got q=%h edges=%0d busy=%0d to=%b exp q=3c edges=8 busy=7 to=0", bus.q, e, b, to); end
    tick();
  endtask

  task automatic test_shift();
    int e, b; bit to;
    logic [3:0] sr_bits;
    sr_bits = 4'b0101;  // bit i is sin_r for step i: 1,0,1,0
    issue(3'd1, 4'd0, 8'hF0); tick();
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd3; bus.cmd_cnt = 4'd4;
    for (int i = 0; i < 4; i++) begin
      bus.sin_r = sr_bits[i];
      tick();
      bus.cmd_valid = 1'b0;
    end
    total++; if (bus.q !== 8'h5F || bus.done !== 1'b1) begin bad++; $display("FAIL shr got q=%h done=%b exp q=5f done=1", bus.q, bus.done); end
    tick();
    bus.sin_l = 1'b1;
    issue(3'd2, 4'd2, 8'h00);
    wait_done(e, b, to);
    total++; if (to || bus.q !== 8'h7F || e !== 2 || b !== 1) begin bad++; $display("FAIL shl got q=%h edges=%0d busy=%0d to=%b exp q=7f edges=2 busy=1 to=0", bus.q, e, b, to); end
    bus.sin_l = 1'b0;
    tick();
  endtask

  task automatic test_abort_illegal();
    bit saw_done;
    issue(3'd1, 4'd0, 8'h5A); tick();
    issue(3'd4, 4'd5, 8'h00);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++; if (bus.q !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL abort got q=%h busy=%b done=%b exp q=00 busy=0 done=0", bus.q, bus.busy, bus.done); end
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL abort_no_done got=%b exp=0", saw_done); end
    issue(3'd1, 4'd0, 8'h33); tick();
    issue(3'd6, 4'd2, 8'hFF);
    total++; if (bus.err !== 1'b1 || bus.done !== 1'b0) begin bad++; $display("FAIL err6 got err=%b done=%b exp err=1 done=0", bus.err, bus.done); end
    total++; if (bus.q !== 8'h33 || bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL err6_state got q=%h ready=%b exp q=33 ready=1", bus.q, bus.cmd_ready); end
    tick();
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL err_pulse got=%b exp=0", bus.err); end
    issue(3'd7, 4'd0, 8'hFF);
    total++; if (bus.err !== 1'b1 || bus.q !== 8'h33) begin bad++; $display("FAIL err7 got err=%b q=%h exp err=1 q=33", bus.err, bus.q); end
    tick();
  endtask

  task automatic test_back_to_back();
    issue(3'd1, 4'd0, 8'h01); tick();
    bus.sin_l = 1'b0;
    issue(3'd2, 4'd2, 8'h00);
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd1; bus.par_in = 8'h99;
    tick();
    total++; if (bus.q !== 8'h04 || bus.done !== 1'b1 || bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL run_ignore got q=%h done=%b ready=%b exp q=04 done=1 ready=1", bus.q, bus.done, bus.cmd_ready); end
    bus.par_in = 8'h11;
    tick();
    bus.cmd_valid = 1'b0;
    total++; if (bus.q !== 8'h11 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_load got q=%h done=%b busy=%b exp q=11 done=1 busy=0", bus.q, bus.done, bus.busy); end
    tick();
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_cnt = 4'd0;
    bus.par_in = 8'h00; bus.sin_l = 1'b0; bus.sin_r = 1'b0;
    test_reset();
    test_load();
    test_rotate();
    test_shift();
    test_abort_illegal();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
